// File: rtl/insn_encoder.sv
// ----------------------------------------------------------------------------
// insn_encoder
//   Packs MIPS instruction fields into 32-bit words (R/I/J formats), buffers
//   them in a DEPTH-entry FIFO and presents them with a valid/ready handshake
//   and a sequential byte address. fmt=3 requests are accepted, dropped and
//   counted.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             synchronous FIFO clear (out_addr, illegal_cnt kept)
//   in_valid/in_ready field-set handshake
//   fmt               0=R, 1=I, 2=J, 3=illegal
//   opcode..target    instruction fields, sampled only on accept
//   out_valid/out_ready output-word handshake
//   out_insn          FIFO head word (0 when empty)
//   out_addr          byte address of out_insn
//   illegal_pulse     one cycle after an illegal request is accepted
//   illegal_cnt       saturating count of dropped requests
// ----------------------------------------------------------------------------
module insn_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h80020000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  sha,
    input  logic [5:0]  func,
    input  logic [15:0] immed,
    input  logic [25:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic [31:0] out_addr,
    output logic        illegal_pulse,
    output logic [7:0]  illegal_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic          pulse_q, pulse_d;
    logic [7:0]    icnt_q, icnt_d;

    logic          accept;
    logic          push;
    logic          pop;
    logic [31:0]   packed_w;

    always_comb begin
        packed_w = '0;
        case (fmt)
            2'd0:    packed_w = {opcode, rs, rt, rd, sha, func};
            2'd1:    packed_w = {opcode, rs, rt, immed};
            default: packed_w = {opcode, target};
        endcase
    end

    // Handshake decoded purely from registered state: no bypass when full.
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_insn  = out_valid ? mem_q[rptr_q] : '0;
    assign out_addr  = addr_q;
    assign illegal_pulse = pulse_q;
    assign illegal_cnt   = icnt_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && (fmt != 2'd3);
    assign pop    = out_valid && out_ready;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        addr_d  = addr_q;
        pulse_d = accept && (fmt == 2'd3);
        icnt_d  = (pulse_d && (icnt_q != 8'hFF)) ? icnt_q + 8'd1 : icnt_q;

        if (flush) begin
            // Any push/pop this cycle is discarded, so out_addr does not advance.
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
                addr_d = addr_q + 32'd4;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            addr_q  <= BASE_ADDR;
            pulse_q <= 1'b0;
            icnt_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            pulse_q <= pulse_d;
            icnt_q  <= icnt_d;
        end
    end

    // Storage is left unreset; out_insn is masked to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem_q[wptr_q] <= packed_w;
        end
    end

endmodule

// File: tb/tb_insn_encoder.sv
module tb_insn_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h80020000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  fmt = '0;
    logic [5:0]  opcode = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, sha = '0;
    logic [5:0]  func = '0;
    logic [15:0] immed = '0;
    logic [25:0] target = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_insn;
    logic [31:0] out_addr;
    logic        illegal_pulse;
    logic [7:0]  illegal_cnt;

    insn_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .sha(sha),
        .func(func), .immed(immed), .target(target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_insn(out_insn), .out_addr(out_addr),
        .illegal_pulse(illegal_pulse), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sha;
        logic [5:0]  func;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [8];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_addr;
    logic [31:0] sb [$];
    int          model_cnt;
    int          exp_icnt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // addi $1,$0,imm : 0x20010000 | imm
    task automatic set_addi(input logic [15:0] imm);
        fmt = 2'd1; opcode = 6'h08; rs = 5'd0; rt = 5'd1; immed = imm;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2'd0, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0000, 26'h0,       32'h00221820};
        vecs[1] = '{2'd1, 6'h09, 5'd4,  5'd5,  5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h0,       32'h2485FFFF};
        vecs[2] = '{2'd2, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0100000, 32'h08100000};
        vecs[3] = '{2'd0, 6'h00, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h0000, 26'h0,       32'h03FFFFFF};
        vecs[4] = '{2'd1, 6'h3F, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0,       32'hFC000000};
        vecs[5] = '{2'd0, 6'h00, 5'd0,  5'd8,  5'd9,  5'd4,  6'h00, 16'h0000, 26'h0,       32'h00084900};
        vecs[6] = '{2'd2, 6'h03, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF};
        vecs[7] = '{2'd1, 6'h23, 5'd29, 5'd31, 5'd0,  5'd0,  6'h00, 16'h0010, 26'h0,       32'h8FBF0010};

        // Reset state
        step();
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_insn", out_insn, 32'h0);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_pulse", 32'(illegal_pulse), 32'd0);
        chk("rst_icnt", 32'(illegal_cnt), 32'd0);
        exp_addr = BASE;

        // Packing table; fields unused by each format get random junk
        for (int i = 0; i < 8; i++) begin
            fmt = vecs[i].fmt; opcode = vecs[i].op;
            rs = vecs[i].rs; rt = vecs[i].rt; rd = vecs[i].rd; sha = vecs[i].sha;
            func = vecs[i].func; immed = vecs[i].imm; target = vecs[i].tgt;
            case (vecs[i].fmt)
                2'd0: begin immed = 16'($urandom); target = 26'($urandom); end
                2'd1: begin rd = 5'($urandom); sha = 5'($urandom); func = 6'($urandom); target = 26'($urandom); end
                default: begin
                    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
                    sha = 5'($urandom); func = 6'($urandom); immed = 16'($urandom);
                end
            endcase
            chk("vec_in_ready", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk("vec_out_valid", 32'(out_valid), 32'd1);
            chk("vec_out_insn", out_insn, vecs[i].exp);
            chk("vec_out_addr", out_addr, exp_addr);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            exp_addr = exp_addr + 32'd4;
            chk("vec_empty_valid", 32'(out_valid), 32'd0);
            chk("vec_empty_insn", out_insn, 32'h0);
            chk("vec_addr_inc", out_addr, exp_addr);
        end

        // Backpressure: DEPTH+2 requests with out_ready low
        model_cnt = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_addi(16'(i));
            in_valid = 1'b1;
            chk("bp_in_ready", 32'(in_ready), 32'(model_cnt < DEPTH));
            if (model_cnt < DEPTH) begin
                sb.push_back(32'h20010000 | 32'(i));
                model_cnt++;
            end
            step();
            chk("bp_head_stable", out_insn, sb[0]);
            chk("bp_addr_stable", out_addr, exp_addr);
        end
        in_valid = 1'b0;
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("bp_drain_valid", 32'(out_valid), 32'd1);
            chk("bp_drain_insn", out_insn, sb.pop_front());
            chk("bp_drain_addr", out_addr, exp_addr);
            step();
            exp_addr = exp_addr + 32'd4;
        end
        for (int i = 0; i < 2; i++) begin
            chk("bp_no_extra", 32'(out_valid), 32'd0);
            chk("bp_addr_hold", out_addr, exp_addr);
            step();
        end
        out_ready = 1'b0;

        // Simultaneous push/pop at count=2
        for (int k = 0; k < 2; k++) begin
            set_addi(16'h0100 + 16'(k));
            in_valid = 1'b1;
            sb.push_back(32'h20010100 + 32'(k));
            step();
        end
        for (int c = 0; c < 10; c++) begin
            set_addi(16'h0200 + 16'(c));
            in_valid = 1'b1;
            out_ready = 1'b1;
            chk("pp_in_ready", 32'(in_ready), 32'd1);
            chk("pp_valid", 32'(out_valid), 32'd1);
            chk("pp_insn", out_insn, sb.pop_front());
            chk("pp_addr", out_addr, exp_addr);
            sb.push_back(32'h20010200 + 32'(c));
            step();
            exp_addr = exp_addr + 32'd4;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("pp_tail_valid", 32'(out_valid), 32'd1);
            chk("pp_tail_insn", out_insn, sb.pop_front());
            chk("pp_tail_addr", out_addr, exp_addr);
            step();
            exp_addr = exp_addr + 32'd4;
        end
        chk("pp_count_was_2", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Illegal requests interleaved with legal words
        exp_icnt = 0;
        for (int i = 0; i < 300; i++) begin
            fmt = 2'd3; opcode = 6'(i); rs = 5'(i); immed = 16'(i);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            if (exp_icnt < 255) exp_icnt++;
            chk("ill_pulse", 32'(illegal_pulse), 32'd1);
            chk("ill_cnt", 32'(illegal_cnt), 32'(exp_icnt));
            chk("ill_not_queued", 32'(out_valid), 32'd0);
            step();
            chk("ill_pulse_once", 32'(illegal_pulse), 32'd0);
            if (i % 50 == 0) begin
                set_addi(16'h0300 + 16'(i));
                in_valid = 1'b1;
                step();
                in_valid = 1'b0;
                chk("ill_legal_pulse", 32'(illegal_pulse), 32'd0);
                chk("ill_legal_insn", out_insn, 32'h20010300 + 32'(i));
                chk("ill_legal_addr", out_addr, exp_addr);
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
                exp_addr = exp_addr + 32'd4;
            end
        end
        chk("ill_saturated", 32'(illegal_cnt), 32'd255);

        // Flush with 3 queued words at out_addr = BASE+8
        do_reset();
        exp_addr = BASE;
        for (int k = 0; k < 2; k++) begin
            set_addi(16'h0400 + 16'(k));
            in_valid = 1'b1;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            out_ready = 1'b0;
        end
        fmt = 2'd3;
        in_valid = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            set_addi(16'h0500 + 16'(k));
            step();
        end
        in_valid = 1'b0;
        chk("fl_pre_addr", out_addr, BASE + 32'd8);
        chk("fl_pre_valid", 32'(out_valid), 32'd1);
        chk("fl_pre_insn", out_insn, 32'h20010500);
        set_addi(16'h0600);
        in_valid = 1'b1;
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_insn", out_insn, 32'h0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        chk("fl_addr_kept", out_addr, BASE + 32'd8);
        chk("fl_icnt_kept", 32'(illegal_cnt), 32'd1);
        set_addi(16'h0700);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("fl_next_valid", 32'(out_valid), 32'd1);
        chk("fl_next_insn", out_insn, 32'h20010700);
        chk("fl_next_addr", out_addr, BASE + 32'd8);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("fl_after_pop_addr", out_addr, BASE + 32'd12);
        chk("fl_after_pop_valid", 32'(out_valid), 32'd0);

        // Reset mid-transfer
        set_addi(16'h0800);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_insn", out_insn, 32'h0);
        chk("mrst_addr", out_addr, BASE);
        chk("mrst_icnt", 32'(illegal_cnt), 32'd0);
        chk("mrst_pulse", 32'(illegal_pulse), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
